// File: rtl/givens_pkg.sv
// Shared types and defaults for the Givens rotation scheduler.
package givens_pkg;

  localparam int unsigned GIVENS_LATENCY = 30;
  localparam int unsigned TAG_IDW        = 3;

  typedef logic [31:0] fp32_t;

  localparam fp32_t FP32_ONE = 32'h3F80_0000;

  // In-flight marker carried alongside each operand pair through the unit
  typedef struct packed {
    logic               valid;
    logic [TAG_IDW-1:0] id;
  } tag_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/givens_sched_rr_arbiter.sv
// Round-robin one-hot arbiter; the search starts at the pointer, which moves past the winner on accept.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NREQ-1:0]           req_i,
  input  logic                      accept_i,
  output logic [NREQ-1:0]           gnt_o,
  output logic [$clog2(NREQ)-1:0]   gnt_id_o
);

  localparam int unsigned IDW = $clog2(NREQ);

  logic [IDW-1:0] ptr_q, ptr_d;

  always_comb begin
    int unsigned idx;
    logic        found;
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_id_o   = IDW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i) ptr_d = (32'(gnt_id_o) == NREQ - 1) ? '0 : gnt_id_o + IDW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/givens_sched.sv
// Time-shares one fixed-latency Givens rotation unit among NREQ requesters with credits and a flush/drain FSM.
// Optional GIVENS_SCHED_STATS_EN adds per-requester issue counters and a stall counter.
module givens_sched
  import givens_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned LATENCY = GIVENS_LATENCY,
  parameter int unsigned MAX_OUT = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*32-1:0]       req_a,
  input  logic [NREQ*32-1:0]       req_b,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     flush,
  output logic                     idle,
  output fp32_t                    rot_a,
  output fp32_t                    rot_b,
  input  fp32_t                    rot_cos,
  input  fp32_t                    rot_sin,
  output logic                     res_valid,
  output logic [$clog2(NREQ)-1:0]  res_id,
  output fp32_t                    res_cos,
  output fp32_t                    res_sin
`ifdef GIVENS_SCHED_STATS_EN
  ,
  output logic [NREQ*16-1:0]       stat_issued,
  output logic [15:0]              stat_stall
`endif
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned CW  = $clog2(MAX_OUT + 1);

  state_e                  state_q, state_d;
  logic                    armed_q;
  logic                    run_c, drain_done_c;
  logic [NREQ-1:0]         elig_c, gnt_c;
  logic [IDW-1:0]          gnt_id_c;
  logic                    xfer_c;
  logic [NREQ-1:0][CW-1:0] credit_q, credit_d;
  tag_t                    pipe_q [LATENCY+1];
  logic                    pipe_busy_c;
  logic                    idle_q;
  fp32_t                   rot_a_q, rot_b_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (flush)  state_d = ST_DRAIN;
      ST_DRAIN: if (idle_q) state_d = ST_RUN;
      default:              state_d = ST_RUN;
    endcase
  end

  always_comb begin
    run_c        = 1'b0;
    drain_done_c = 1'b0;
    case (state_q)
      ST_RUN:   run_c        = armed_q;
      ST_DRAIN: drain_done_c = idle_q;
      default:  ;
    endcase
  end

  // Holds grants off for the first cycle out of reset so req_ready stays 0 while in reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) armed_q <= 1'b0;
    else          armed_q <= 1'b1;
  end

  always_comb begin
    for (int i = 0; i < int'(NREQ); i++)
      elig_c[i] = req_valid[i] & (credit_q[i] != '0) & run_c;
  end

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .req_i    (elig_c),
    .accept_i (xfer_c),
    .gnt_o    (gnt_c),
    .gnt_id_o (gnt_id_c)
  );

  assign xfer_c    = |gnt_c;
  assign req_ready = gnt_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rot_a_q <= '0;
      rot_b_q <= '0;
    end else if (xfer_c) begin
      rot_a_q <= req_a[32*gnt_id_c +: 32];
      rot_b_q <= req_b[32*gnt_id_c +: 32];
    end
  end

  // Tag pipe: stage k holds the issue from k+1 cycles ago; the last stage lines up with the unit output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k <= int'(LATENCY); k++) pipe_q[k] <= '0;
    end else begin
      pipe_q[0] <= '{valid: xfer_c, id: xfer_c ? TAG_IDW'(gnt_id_c) : '0};
      for (int k = 1; k <= int'(LATENCY); k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  always_comb begin
    pipe_busy_c = 1'b0;
    for (int k = 0; k < int'(LATENCY); k++) pipe_busy_c = pipe_busy_c | pipe_q[k].valid;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) idle_q <= 1'b1;
    else          idle_q <= ~(xfer_c | pipe_busy_c);
  end

  assign res_valid = pipe_q[LATENCY].valid;
  assign res_id    = IDW'(pipe_q[LATENCY].id);
  assign res_cos   = res_valid ? rot_cos : '0;
  assign res_sin   = res_valid ? rot_sin : '0;
  assign rot_a     = rot_a_q;
  assign rot_b     = rot_b_q;
  assign idle      = idle_q;

  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      credit_d[i] = credit_q[i];
      if ((res_valid && res_id == IDW'(i)) && !gnt_c[i]) credit_d[i] = credit_q[i] + CW'(1);
      else if (gnt_c[i] && !(res_valid && res_id == IDW'(i))) credit_d[i] = credit_q[i] - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NREQ); i++) credit_q[i] <= CW'(MAX_OUT);
    end else begin
      credit_q <= credit_d;
    end
  end

`ifdef GIVENS_SCHED_STATS_EN
  logic [NREQ-1:0][15:0] issued_q;
  logic [15:0]           stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else if (drain_done_c) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      for (int i = 0; i < int'(NREQ); i++)
        if (gnt_c[i] && issued_q[i] != 16'hFFFF) issued_q[i] <= issued_q[i] + 16'd1;
      if ((|req_valid) && !xfer_c && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  end

  assign stat_issued = issued_q;
  assign stat_stall  = stall_q;
`endif

endmodule

// File: tb/tb_givens_sched.sv
// Bench for givens_sched: rotation-unit model, in-order scoreboard, arbitration table and corner sequences.
module tb_givens_sched;
  import givens_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned LAT  = GIVENS_LATENCY;
  localparam int unsigned MAXO = 8;
  localparam int unsigned IDW  = 2;

  logic              clk;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*32-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready;
  logic              flush;
  logic              idle;
  fp32_t             rot_a, rot_b, rot_cos, rot_sin;
  logic              res_valid;
  logic [IDW-1:0]    res_id;
  fp32_t             res_cos, res_sin;
`ifdef GIVENS_SCHED_STATS_EN
  logic [NREQ*16-1:0] stat_issued;
  logic [15:0]        stat_stall;
`endif

  givens_sched #(.NREQ(NREQ), .LATENCY(LAT), .MAX_OUT(MAXO)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .flush(flush), .idle(idle), .rot_a(rot_a), .rot_b(rot_b),
    .rot_cos(rot_cos), .rot_sin(rot_sin), .res_valid(res_valid), .res_id(res_id),
    .res_cos(res_cos), .res_sin(res_sin)
`ifdef GIVENS_SCHED_STATS_EN
    , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic fp32_t cos_f(fp32_t a, fp32_t b);
    return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic fp32_t sin_f(fp32_t a, fp32_t b);
    return a + b + 32'h1;
  endfunction

  // Rotation unit model: non-resettable LATENCY-deep delay of rot_a/rot_b
  fp32_t ua [LAT];
  fp32_t ub [LAT];
  always @(posedge clk) begin
    ua[0] <= rot_a;
    ub[0] <= rot_b;
    for (int k = 1; k < int'(LAT); k++) begin
      ua[k] <= ua[k-1];
      ub[k] <= ub[k-1];
    end
  end
  assign rot_cos = cos_f(ua[LAT-1], ub[LAT-1]);
  assign rot_sin = sin_f(ua[LAT-1], ub[LAT-1]);

  typedef struct {
    logic [IDW-1:0] id;
    fp32_t          a;
    fp32_t          b;
    int unsigned    cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_res = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: push on observed transfer, pop and compare on each result
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      sb.delete();
    end else begin
      if (res_valid) begin
        n_res++;
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL res_valid with nothing in flight: id %0d cycle %0d", res_id, cyc);
        end else begin
          e = sb.pop_front();
          check("res_id", 64'(res_id), 64'(e.id));
          check("res_cos", 64'(res_cos), 64'(cos_f(e.a, e.b)));
          check("res_sin", 64'(res_sin), 64'(sin_f(e.a, e.b)));
          check("req-to-res latency", 64'(cyc - e.cyc), 64'(LAT + 1));
        end
      end
      if ((req_valid & req_ready) != '0) begin
        check("grant onehot", 64'($onehot(req_ready)), 64'd1);
        for (int i = 0; i < int'(NREQ); i++)
          if (req_valid[i] && req_ready[i]) begin
            e.id  = IDW'(i);
            e.a   = req_a[32*i +: 32];
            e.b   = req_b[32*i +: 32];
            e.cyc = cyc;
            sb.push_back(e);
          end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    req_a = {$urandom, $urandom, $urandom, $urandom};
    req_b = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (idle && sb.size() == 0) ok = 1'b1;
    end
    check("drain to idle within budget", 64'(ok), 64'd1);
    tick();
  endtask

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [NREQ-1:0] ready;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int unsigned t0;
    int          n0;
    logic        got;

    // Arbitration table; pointer is 1 after the single-issue test
    tbl[0]  = '{4'b0001, 4'b0001};
    tbl[1]  = '{4'b1010, 4'b0010};
    tbl[2]  = '{4'b1010, 4'b1000};
    tbl[3]  = '{4'b0110, 4'b0010};
    tbl[4]  = '{4'b0111, 4'b0100};
    tbl[5]  = '{4'b0011, 4'b0001};
    tbl[6]  = '{4'b0000, 4'b0000};
    tbl[7]  = '{4'b1101, 4'b0100};
    tbl[8]  = '{4'b1111, 4'b1000};
    tbl[9]  = '{4'b1001, 4'b0001};
    tbl[10] = '{4'b1100, 4'b0100};
    tbl[11] = '{4'b0101, 4'b0001};

    reset_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", 64'(req_ready), 64'd0);
    check("reset rot_a", 64'(rot_a), 64'd0);
    check("reset rot_b", 64'(rot_b), 64'd0);
    check("reset res_valid", 64'(res_valid), 64'd0);
    check("reset res_id", 64'(res_id), 64'd0);
    check("reset res_cos", 64'(res_cos), 64'd0);
    check("reset res_sin", 64'(res_sin), 64'd0);
    check("reset idle", 64'(idle), 64'd1);
    tick();
    reset_n = 1'b1;
    repeat (2) tick();

    // Single issue from requester 0
    rand_data();
    req_a[31:0] = FP32_ONE;
    req_b[31:0] = 32'h0;
    req_valid   = 4'b0001;
    t0 = cyc;
    @(negedge clk);
    check("single grant", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    check("rot_a registered", 64'(rot_a), 64'(FP32_ONE));
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (res_valid) begin
        got = 1'b1;
        check("single latency", 64'(cyc - t0), 64'(LAT + 1));
        check("single res_id", 64'(res_id), 64'd0);
        check("single res_cos", 64'(res_cos), 64'(cos_f(FP32_ONE, 32'h0)));
        check("single res_sin", 64'(res_sin), 64'(sin_f(FP32_ONE, 32'h0)));
      end
    end
    check("single result seen", 64'(got), 64'd1);
    wait_idle();

    for (int i = 0; i < 12; i++) begin
      rand_data();
      req_valid = tbl[i].valid;
      @(negedge clk);
      check($sformatf("arb vector %0d", i), 64'(req_ready), 64'(tbl[i].ready));
      tick();
    end
    req_valid = '0;
    wait_idle();

    // Asynchronous reset mid-stream
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin rand_data(); tick(); end
    reset_n = 1'b0;
    #1;
    check("midreset req_ready", 64'(req_ready), 64'd0);
    check("midreset rot_a", 64'(rot_a), 64'd0);
    check("midreset res_valid", 64'(res_valid), 64'd0);
    check("midreset idle", 64'(idle), 64'd1);
    req_valid = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    n0 = n_res;
    repeat (LAT + 10) tick();
    check("no results from pre-reset issues", 64'(n_res - n0), 64'd0);

    // All requesters valid: pointer restarts at 0
    req_valid = '1;
    n0 = n_res;
    for (int k = 0; k < 40; k++) begin
      rand_data();
      @(negedge clk);
      check("rr all-valid grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      tick();
    end
    req_valid = '0;
    wait_idle();
    check("all-valid result count", 64'(n_res - n0), 64'd40);

    // Credit limit on requester 1
    req_valid = 4'b0010;
    for (int k = 0; k < 40; k++) begin
      rand_data();
      @(negedge clk);
      check("credit-limited ready", 64'(req_ready[1]), 64'((k < 8) || (k >= 32)));
      tick();
    end
    req_valid = '0;
    wait_idle();

    // Flush with 5 in flight
    for (int k = 0; k < 40; k++) begin
      rand_data();
      req_valid = (k < 38) ? 4'b1111 : 4'b0000;
      flush     = (k == 4);
      @(negedge clk);
      if (k < 5) check("flush pre-grant", 64'(req_ready != '0), 64'd1);
      else if (k <= 36) begin
        check("drain ready", 64'(req_ready), 64'd0);
        check("drain idle", 64'(idle), 64'(k == 36));
      end else if (k == 37) check("grant resumes", 64'(req_ready != '0), 64'd1);
      tick();
    end
    flush = 1'b0;
    wait_idle();

`ifdef GIVENS_SCHED_STATS_EN
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    @(negedge clk);
    check("stats cleared issued", 64'(stat_issued), 64'd0);
    check("stats cleared stall", 64'(stat_stall), 64'd0);
    tick();
    for (int k = 0; k < 13; k++) begin
      rand_data();
      req_valid = (k < 10) ? 4'b0010 : 4'b0100;
      tick();
    end
    req_valid = '0;
    @(negedge clk);
    check("stat_issued[2]", 64'(stat_issued[32 +: 16]), 64'd3);
    check("stat_issued[1]", 64'(stat_issued[16 +: 16]), 64'd8);
    check("stat_stall", 64'(stat_stall), 64'd2);
    tick();
    wait_idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    @(negedge clk);
    check("stats zero after drain issued", 64'(stat_issued), 64'd0);
    check("stats zero after drain stall", 64'(stat_stall), 64'd0);
    tick();
`endif

    check("scoreboard empty at end", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
